// File: rtl/noc_vc_input_port.sv
// Multi-VC router input port: one link demultiplexed into NUM_VC FWFT queues with per-VC credit return.
// Optional per-VC high-water-mark tracking is built when NOC_VCIN_HWM_EN is defined.
module noc_vc_input_port #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned NUM_VC = 2,
    parameter int unsigned VC_W   = 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        data_i,
    input  logic                     valid_i,
    input  logic [VC_W-1:0]          vc_i,
    input  logic [NUM_VC-1:0]        shift_i,
    output logic [NUM_VC*DATA_W-1:0] data_o,
    output logic [NUM_VC-1:0]        valid_o,
    output logic [NUM_VC-1:0]        credit_o,
    output logic [NUM_VC*CNT_W-1:0]  count_o,
    output logic [1:0]               err_o,
    input  logic                     hwm_clr_i,
    output logic [NUM_VC*CNT_W-1:0]  hwm_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q    [NUM_VC][DEPTH];
    logic [DATA_W-1:0] mem_d    [NUM_VC][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [NUM_VC];
    logic [PTR_W-1:0]  wr_ptr_d [NUM_VC];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_VC];
    logic [PTR_W-1:0]  rd_ptr_d [NUM_VC];
    logic [CNT_W-1:0]  count_q  [NUM_VC];
    logic [CNT_W-1:0]  count_d  [NUM_VC];
    logic [NUM_VC-1:0] credit_q;
    logic [NUM_VC-1:0] credit_d;
    logic [1:0]        err_q;
    logic [1:0]        err_d;

    logic [NUM_VC-1:0] pop_c;
    logic [NUM_VC-1:0] wr_acc_c;
    logic              vc_ok_c;
    logic              ovf_c;
    logic              uerr_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Per-VC write acceptance, pop qualification, pointer/count update and error capture
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        credit_d = '0;
        pop_c    = '0;
        wr_acc_c = '0;
        ovf_c    = 1'b0;
        uerr_c   = 1'b0;
        vc_ok_c  = (32'(vc_i) < NUM_VC);

        if (valid_i && !vc_ok_c) begin
            uerr_c = 1'b1;
        end

        for (int v = 0; v < int'(NUM_VC); v++) begin
            pop_c[v] = shift_i[v] && (count_q[v] != '0);
            if (shift_i[v] && (count_q[v] == '0)) begin
                uerr_c = 1'b1;
            end

            // A full VC still accepts a write when it is popped in the same cycle
            if (valid_i && vc_ok_c && (vc_i == VC_W'(v))) begin
                if ((count_q[v] != CNT_W'(DEPTH)) || pop_c[v]) begin
                    wr_acc_c[v] = 1'b1;
                end else begin
                    ovf_c = 1'b1;
                end
            end

            if (wr_acc_c[v]) begin
                mem_d[v][wr_ptr_q[v]] = data_i;
                wr_ptr_d[v]           = ptr_inc(wr_ptr_q[v]);
            end
            if (pop_c[v]) begin
                rd_ptr_d[v] = ptr_inc(rd_ptr_q[v]);
            end

            if (wr_acc_c[v] && !pop_c[v]) begin
                count_d[v] = count_q[v] + CNT_W'(1);
            end else if (!wr_acc_c[v] && pop_c[v]) begin
                count_d[v] = count_q[v] - CNT_W'(1);
            end

            credit_d[v] = pop_c[v];
        end

        err_d = err_q | {uerr_c, ovf_c};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < int'(NUM_VC); v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                count_q[v]  <= '0;
            end
            credit_q <= '0;
            err_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

    // Flit storage carries no reset; its contents are meaningless while a VC is empty
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        data_o  = '0;
        count_o = '0;
        valid_o = '0;
        for (int v = 0; v < int'(NUM_VC); v++) begin
            data_o[v*DATA_W +: DATA_W] = mem_q[v][rd_ptr_q[v]];
            count_o[v*CNT_W +: CNT_W]  = count_q[v];
            valid_o[v]                 = (count_q[v] != '0);
        end
    end

    assign credit_o = credit_q;
    assign err_o    = err_q;

`ifdef NOC_VCIN_HWM_EN
    logic [CNT_W-1:0] hwm_q [NUM_VC];
    logic [CNT_W-1:0] hwm_d [NUM_VC];

    // Tracks registered count, so the mark trails a count change by one cycle
    always_comb begin
        hwm_d = hwm_q;
        for (int v = 0; v < int'(NUM_VC); v++) begin
            if (hwm_clr_i) begin
                hwm_d[v] = count_q[v];
            end else if (count_q[v] > hwm_q[v]) begin
                hwm_d[v] = count_q[v];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < int'(NUM_VC); v++) begin
                hwm_q[v] <= '0;
            end
        end else begin
            hwm_q <= hwm_d;
        end
    end

    always_comb begin
        hwm_o = '0;
        for (int v = 0; v < int'(NUM_VC); v++) begin
            hwm_o[v*CNT_W +: CNT_W] = hwm_q[v];
        end
    end
`else
    logic unused_hwm_clr;

    assign unused_hwm_clr = hwm_clr_i;
    assign hwm_o          = '0;
`endif

endmodule

// File: doc/noc_vc_input_port.md
Name: noc_vc_input_port

Overview:
- Parametrised successor to the router's single-queue input port: one physical link feeding NUM_VC independent virtual-channel FIFOs.
- Each VC has its own first-word-fall-through queue, per-VC occupancy count and per-VC credit return to the upstream router.
- Sits between a link's data_i/valid_i/credit_o signals and the route logic and crossbar, which see one head flit per VC.

Parameters:
- DATA_W, 16, flit width in bits.
- DEPTH, 4, entries per VC FIFO (>=2; need not be a power of two).
- NUM_VC, 2, number of virtual channels (>=1).
- VC_W, 1, width of the VC select field; must satisfy 2**VC_W >= NUM_VC.
- CNT_W = $clog2(DEPTH+1) is a local parameter, not overridable.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_i  in  DATA_W  incoming flit.
- valid_i  in  1  flit present this cycle.
- vc_i  in  VC_W  destination VC of the incoming flit.
- shift_i  in  NUM_VC  per-VC pop request from route logic.
- data_o  out  NUM_VC*DATA_W  head flit per VC; VC v occupies bits [v*DATA_W +: DATA_W].
- valid_o  out  NUM_VC  VC v is non-empty.
- credit_o  out  NUM_VC  one-cycle credit pulse per successful pop.
- count_o  out  NUM_VC*CNT_W  per-VC occupancy.
- err_o  out  2  sticky errors: bit0 = overflow, bit1 = bad VC or underflow.
- hwm_clr_i  in  1  clear high-water marks (used only with the optional feature).
- hwm_o  out  NUM_VC*CNT_W  per-VC high-water mark (used only with the optional feature).

Behaviour:
- Reset (asynchronous, rst=1):
  - All read and write pointers, counts, credit_o, err_o and hwm_o go to 0.
  - valid_o = 0.
  - data_o reads storage and is don't-care while valid_o = 0.
- Write:
  - On a clk edge with valid_i=1 and vc_i<NUM_VC, the flit is stored at wr_ptr[vc_i], and wr_ptr[vc_i] advances.
  - wr_ptr wraps from DEPTH-1 to 0.
- Write latency: the written flit is visible on data_o/valid_o one cycle later. There is no same-cycle bypass.
- Read:
  - data_o for each VC is its head entry, combinational from storage (FWFT).
  - A pop occurs when shift_i[v]=1 and valid_o[v]=1; rd_ptr[v] advances with the same wrap rule.
- Count per VC:
  - +1 on an accepted write only.
  - -1 on a pop only.
  - Unchanged when both happen in the same cycle.
  - Never exceeds DEPTH and never goes below 0.
- Full VC (count=DEPTH):
  - A write with no same-cycle pop on that VC is dropped; storage and pointers are unchanged and err_o[0] is set.
  - A write with a same-cycle pop on that VC is accepted; count stays at DEPTH.
- Empty VC:
  - shift_i[v] is ignored and err_o[1] is set.
  - A simultaneous write still lands; the flit appears next cycle.
- Invalid VC: valid_i=1 with vc_i>=NUM_VC drops the flit and sets err_o[1].
- Credits:
  - credit_o[v] is registered and equals 1 exactly in the cycle after a pop on v.
  - Multiple VCs may pulse together.
  - Upstream starts with DEPTH credits per VC.
- Sticky errors: err_o bits clear only on reset.
- Reset mid-operation: all queued flits are lost, and any pending credit pulse is suppressed. Upstream credit counters must be reset on the same rst.

Optional Feature:
- Macro: NOC_VCIN_HWM_EN.
- Defined:
  - hwm_o[v] holds the maximum count_o[v] seen since reset or the last clear. It updates in the cycle after count changes.
  - hwm_clr_i=1 loads the current count on the next edge; this takes priority over a same-cycle update.
- Undefined:
  - No high-water-mark registers are built, and hwm_o is tied to 0.
  - hwm_clr_i is ignored; the ports remain present for a stable interface.

Test Plan:
- Reset, then write 0xA001 and 0xA002 to VC0 on consecutive cycles:
  - valid_o=01 one cycle after the first write; data_o[15:0]=0xA001; count_o VC0=2.
- Pop VC0 twice:
  - data_o shows 0xA001, then 0xA002; credit_o[0] pulses in the cycle after each pop; count returns to 0 with valid_o[0]=0.
- Write 5 flits to VC1 (DEPTH=4) without popping:
  - First 4 accepted, count=4; 5th dropped, err_o[0]=1; VC0 unaffected.
- VC1 full, write 0xBEEF with shift_i=10 in the same cycle:
  - Accepted; count stays 4; after 4 pops the last flit read is 0xBEEF; pointers wrap correctly.
- shift_i=01 on empty VC0, and separately valid_i=1 with vc_i=1 when NUM_VC=1 (second build):
  - err_o[1]=1, no pointer change, no credit pulse.
- Write 3 flits to VC0, then assert rst for one cycle mid-stream:
  - Immediately after rst: count_o=0, valid_o=0, credit_o=0, err_o=0.
  - With NOC_VCIN_HWM_EN defined: hwm_o VC0=3 before reset and 0 after.
